// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Definitions shared by the UART transmitter and the receiver that reuses
//   this package:
//     state_e        - frame FSM states (idle, start, data, parity, stop)
//     PAR_*          - parity-mode encodings for the PARITY parameter
//     clks_per_bit() - system clocks per line bit (floor of freq / baud)
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
//   Bit-period counter. Counts 0..CLKS_PER_BIT-1 and raises tick for one
//   clock at the terminal count, then wraps to 0.
//   Ports:
//     clk   in  system clock
//     rst   in  synchronous, active-high reset (counter to 0)
//     clr   in  synchronous clear; holds the counter at 0, no tick
//     tick  out one-clock pulse at terminal count
// -----------------------------------------------------------------------------
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    tick  = 1'b0;
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q == TERM) begin
      cnt_d = '0;
      tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: flops use non-blocking assignments so every flop samples the values
  // from before the edge, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// -----------------------------------------------------------------------------
// uart_tx_cfg
//   Configurable UART transmitter. One word per valid/ready handshake is sent
//   as: start bit (0), DATA_BITS data bits LSB first, optional parity bit,
//   then STOP_BITS stop bits (1). Bit timing comes from uart_baud_gen.
//   Ports:
//     clk       in  system clock
//     rst       in  synchronous, active-high reset; abandons any frame
//     tx_valid  in  word on tx_data is valid
//     tx_data   in  word to send, captured on the handshake cycle
//     tx_ready  out high only while idle
//     tx        out serial line, idles high
//     tx_busy   out inverse of tx_ready
//     tx_done   out one-clock pulse as the last stop bit completes
// -----------------------------------------------------------------------------
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 1000000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int BCW = $clog2(DATA_BITS + 1);
  localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $fatal(1, "uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_parity
    $fatal(1, "uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $fatal(1, "uart_tx_cfg: STOP_BITS must be 1 or 2");
  end
  if (CPB < 2) begin : g_bad_cpb
    $fatal(1, "uart_tx_cfg: CLK_FREQ/BAUD_RATE must be at least 2");
  end

  state_e                 state_q, state_d;
  logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   tx_q, tx_d;
  logic                   done_q, done_d;
  logic                   bit_tick;
  logic                   handshake;

  assign tx_ready  = (state_q == ST_IDLE);
  assign tx_busy   = ~tx_ready;
  assign tx        = tx_q;
  assign tx_done   = done_q;
  assign handshake = tx_valid & tx_ready;

  // Holding the counter clear for the whole idle period makes the handshake
  // cycle the clear point, so the start bit gets a full bit period.
  uart_baud_gen #(
    .CLKS_PER_BIT (CPB)
  ) u_baud_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (tx_ready),
    .tick (bit_tick)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    done_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          shift_d   = tx_data;
          par_d     = (PARITY == PAR_EVEN) ? ^tx_data : ~^tx_data;
          bit_cnt_d = '0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (bit_tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_tick) state_d = ST_STOP;
      end
      ST_STOP: begin
        // The bit counter is reused to count stop bits.
        if (bit_tick) begin
          if (bit_cnt_q == LAST_STOP) begin
            bit_cnt_d = '0;
            done_d    = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The line is registered from the next-state values, so tx changes on the
    // same edge as the state and each bit lasts exactly one bit period.
    unique case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

  // NOTE: the shift register has no reset; it is always loaded on the
  // handshake before any of its bits reach the line.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_cfg
//   Self-checking bench for uart_tx_cfg. Seven instances cover 8N1, 8E1, 8O1,
//   7E2 at 104 clks/bit, and fast 8N1 (2 clks/bit), 9O2 and 5E1 (3 clks/bit).
//   Expected frames come from a table of hand-derived patterns and from a
//   frame-building reference model.
// -----------------------------------------------------------------------------
module tb_uart_tx_cfg;
  import uart_pkg::*;

  localparam int N = 7;
  localparam int CPB_T [N] = '{104, 104, 104, 104, 2, 3, 3};
  localparam int DB_T  [N] = '{8, 8, 8, 7, 8, 9, 5};
  localparam int PAR_T [N] = '{0, 2, 1, 2, 0, 1, 2};
  localparam int SB_T  [N] = '{1, 1, 1, 2, 1, 2, 1};

  typedef logic [0:15] pat_t;  // pat[k] = k-th bit on the line
  typedef struct {
    int         inst;
    logic [8:0] data;
    int         len;
    pat_t       pat;
    bit         noise;
  } vec_t;

  logic             clk;
  logic             rst;
  logic [N-1:0]     vld;
  logic [8:0]       dat [N];
  logic [N-1:0]     rdy, txl, bsy, dn;

  int total;
  int bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(9600), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .tx_valid(vld[0]), .tx_data(dat[0][7:0]),
    .tx_ready(rdy[0]), .tx(txl[0]), .tx_busy(bsy[0]), .tx_done(dn[0]));
  uart_tx_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(9600), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .tx_valid(vld[1]), .tx_data(dat[1][7:0]),
    .tx_ready(rdy[1]), .tx(txl[1]), .tx_busy(bsy[1]), .tx_done(dn[1]));
  uart_tx_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(9600), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .tx_valid(vld[2]), .tx_data(dat[2][7:0]),
    .tx_ready(rdy[2]), .tx(txl[2]), .tx_busy(bsy[2]), .tx_done(dn[2]));
  uart_tx_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(9600), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .tx_valid(vld[3]), .tx_data(dat[3][6:0]),
    .tx_ready(rdy[3]), .tx(txl[3]), .tx_busy(bsy[3]), .tx_done(dn[3]));
  uart_tx_cfg #(.CLK_FREQ(20), .BAUD_RATE(10), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u4 (
    .clk(clk), .rst(rst), .tx_valid(vld[4]), .tx_data(dat[4][7:0]),
    .tx_ready(rdy[4]), .tx(txl[4]), .tx_busy(bsy[4]), .tx_done(dn[4]));
  uart_tx_cfg #(.CLK_FREQ(30), .BAUD_RATE(10), .DATA_BITS(9), .PARITY(1), .STOP_BITS(2)) u5 (
    .clk(clk), .rst(rst), .tx_valid(vld[5]), .tx_data(dat[5][8:0]),
    .tx_ready(rdy[5]), .tx(txl[5]), .tx_busy(bsy[5]), .tx_done(dn[5]));
  uart_tx_cfg #(.CLK_FREQ(30), .BAUD_RATE(10), .DATA_BITS(5), .PARITY(2), .STOP_BITS(1)) u6 (
    .clk(clk), .rst(rst), .tx_valid(vld[6]), .tx_data(dat[6][4:0]),
    .tx_ready(rdy[6]), .tx(txl[6]), .tx_busy(bsy[6]), .tx_done(dn[6]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: assemble the frame bit by bit from the framing rules.
  function automatic pat_t model_frame(input int i, input logic [8:0] w, output int len);
    pat_t       p;
    int         k;
    logic [8:0] d;
    p = '0;
    k = 0;
    d = w & ((9'd1 << DB_T[i]) - 9'd1);
    p[k] = 1'b0; k++;
    for (int b = 0; b < DB_T[i]; b++) begin
      p[k] = d[b]; k++;
    end
    if (PAR_T[i] == PAR_ODD) begin
      p[k] = ~^d; k++;
    end else if (PAR_T[i] == PAR_EVEN) begin
      p[k] = ^d; k++;
    end
    for (int s = 0; s < SB_T[i]; s++) begin
      p[k] = 1'b1; k++;
    end
    len = k;
    return p;
  endfunction

  // Called at a negedge: wait (bounded) for ready, then present the word.
  task automatic start_word(input int i, input logic [8:0] w);
    int n;
    n = 0;
    while (rdy[i] !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(rdy[i]), 32'd1);
    vld[i] = 1'b1;
    dat[i] = w;
  endtask

  // Called at the negedge where the word is presented; the next posedge is
  // the handshake. Samples every cycle of the frame at the negedge.
  task automatic check_frame(input int i, input string tag, input pat_t pat, input int len,
                             input bit chain, input logic [8:0] nxt, input bit noise);
    int line_err;
    int ctrl_err;
    int first_bad;
    int cyc;
    line_err  = 0;
    ctrl_err  = 0;
    first_bad = -1;
    cyc       = len * CPB_T[i];
    @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < cyc; c++) begin
      if (txl[i] !== pat[c / CPB_T[i]]) begin
        line_err++;
        if (first_bad < 0) first_bad = c;
      end
      if (rdy[i] !== 1'b0 || bsy[i] !== 1'b1 || dn[i] !== 1'b0) ctrl_err++;
      if (c == 0) vld[i] = 1'b0;
      if (noise && $urandom_range(0, 15) == 0) begin
        vld[i] = 1'($urandom_range(0, 1));
        dat[i] = 9'($urandom);
      end
      @(negedge clk);
    end
    check($sformatf("%s_line(first_bad_clk=%0d)", tag, first_bad), 32'(line_err), 32'd0);
    check({tag, "_ctrl"}, 32'(ctrl_err), 32'd0);
    // done, ready, busy, tx at the cycle the last stop bit completes
    check({tag, "_end"}, 32'({dn[i], rdy[i], bsy[i], txl[i]}), 32'b1101);
    if (chain) begin
      vld[i] = 1'b1;
      dat[i] = nxt;
    end else begin
      vld[i] = 1'b0;
      @(negedge clk);
      check({tag, "_pulse"}, 32'({dn[i], rdy[i], txl[i]}), 32'b011);
    end
  endtask

  vec_t vecs [5];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    pat_t       p;
    int         len;
    int         cnt_done;
    int         cnt_low;
    logic [8:0] w;
    logic [8:0] nw;
    bit         pend;
    bit         ch;

    total = 0;
    bad   = 0;
    rst   = 1'b1;
    vld   = '0;
    for (int i = 0; i < N; i++) dat[i] = '0;

    // Hand-derived frames from the framing rules.
    vecs[0] = '{inst: 0, data: 9'h0A5, len: 10, pat: 16'b0101001011000000, noise: 1'b0};
    vecs[1] = '{inst: 1, data: 9'h0A5, len: 11, pat: 16'b0101001010100000, noise: 1'b0};
    vecs[2] = '{inst: 2, data: 9'h0A5, len: 11, pat: 16'b0101001011100000, noise: 1'b0};
    vecs[3] = '{inst: 3, data: 9'h041, len: 11, pat: 16'b0100000101100000, noise: 1'b1};
    vecs[4] = '{inst: 4, data: 9'h0FF, len: 10, pat: 16'b0111111111000000, noise: 1'b0};

    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++)
      check($sformatf("reset_state_u%0d", i), 32'({dn[i], rdy[i], bsy[i], txl[i]}), 32'b0101);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      start_word(vecs[v].inst, vecs[v].data);
      check_frame(vecs[v].inst, $sformatf("vec%0d", v), vecs[v].pat, vecs[v].len,
                  1'b0, 9'h000, vecs[v].noise);
    end

    // Back-to-back with tx_valid held: one idle-high clock between frames.
    start_word(0, 9'h055);
    p = model_frame(0, 9'h055, len);
    check_frame(0, "b2b_first", p, len, 1'b1, 9'h00F, 1'b0);
    p = model_frame(0, 9'h00F, len);
    check_frame(0, "b2b_second", p, len, 1'b0, 9'h000, 1'b0);

    // tx_valid / tx_data churning mid-frame must not disturb the frame.
    start_word(0, 9'h096);
    p = model_frame(0, 9'h096, len);
    check_frame(0, "noise", p, len, 1'b0, 9'h000, 1'b1);

    // Reset during the 3rd data bit (line bit index 3) of 0xC3.
    start_word(0, 9'h0C3);
    @(posedge clk);
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (3 * 104 + 40) @(negedge clk);
    check("rst_mid_bit", 32'(txl[0]), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_abort", 32'({dn[0], rdy[0], bsy[0], txl[0]}), 32'b0101);
    rst = 1'b0;
    cnt_done = 0;
    cnt_low  = 0;
    repeat (1200) begin
      @(negedge clk);
      if (dn[0] !== 1'b0) cnt_done++;
      if (txl[0] !== 1'b1) cnt_low++;
    end
    check("rst_no_done", 32'(cnt_done), 32'd0);
    check("rst_line_idle", 32'(cnt_low), 32'd0);
    start_word(0, 9'h03C);
    p = model_frame(0, 9'h03C, len);
    check_frame(0, "after_rst", p, len, 1'b0, 9'h000, 1'b0);

    // Randomised frames against the model, with random chaining and noise.
    for (int i = 1; i < N; i++) begin
      int k_max;
      k_max = (CPB_T[i] > 10) ? 2 : 20;
      w     = 9'($urandom);
      pend  = 1'b0;
      for (int k = 0; k < k_max; k++) begin
        nw = 9'($urandom);
        ch = (k < k_max - 1) && ($urandom_range(0, 1) == 1);
        if (!pend) start_word(i, w);
        p = model_frame(i, w, len);
        check_frame(i, $sformatf("rnd_u%0d_%0d", i, k), p, len, ch, nw, 1'b1);
        w    = nw;
        pend = ch;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
